// File: rtl/interp_pkg.sv
// Shared definitions for the interpolation feed sequencer: state encoding,
// parameter defaults and the phase at which a new sample is fetched.
package interp_pkg;

  localparam int SAMPLE_RATE_DEF = 4;
  localparam int DATAWIDTH_DEF   = 14;
  localparam int UCNT_W_DEF      = 8;

  // Encoding 2'd3 is unused and falls back to IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  // Read is issued three clocks before the segment ends:
  // one clock of FIFO latency, one to register, one to present
  function automatic int phase_fetch(input int n);
    return n - 3;
  endfunction

endpackage

// File: rtl/interp_phase_cnt.sv
// Wrapping segment phase counter, 0..2^SAMPLE_RATE-1, with decodes for the
// fetch phase and the last phase of a segment.
module interp_phase_cnt
  import interp_pkg::*;
#(
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr_i,
  input  logic                   inc_i,
  output logic [SAMPLE_RATE-1:0] phase_o,
  output logic                   phase_at_fetch_o,
  output logic                   phase_at_last_o
);

  localparam int N = 1 << SAMPLE_RATE;
  localparam logic [SAMPLE_RATE-1:0] PHASE_FETCH = SAMPLE_RATE'(phase_fetch(N));
  localparam logic [SAMPLE_RATE-1:0] PHASE_LAST  = SAMPLE_RATE'(N - 1);

  logic [SAMPLE_RATE-1:0] phase_q, phase_d;

  // Next phase: clear has priority, increment wraps naturally at N-1
  always_comb begin
    phase_d = phase_q;
    if (clr_i) begin
      phase_d = '0;
    end else if (inc_i) begin
      phase_d = phase_q + 1'b1;
    end
  end

  // Phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

  assign phase_o          = phase_q;
  assign phase_at_fetch_o = (phase_q == PHASE_FETCH);
  assign phase_at_last_o  = (phase_q == PHASE_LAST);

endmodule

// File: rtl/interp_feed_ctrl.sv
// Feed sequencer for the linear-interpolation upsampler. Primes two samples
// from the FIFO, then fetches one sample per segment, drives the segment
// phase and tracks underruns. Owns all FIFO read timing.
module interp_feed_ctrl
  import interp_pkg::*;
#(
  parameter int SAMPLE_RATE = SAMPLE_RATE_DEF,
  parameter int DATAWIDTH   = DATAWIDTH_DEF,
  parameter int UCNT_W      = UCNT_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable_i,
  input  logic                   fifo_half_i,
  input  logic                   fifo_empty_i,
  input  logic [DATAWIDTH-1:0]   fifo_dout_i,
  input  logic                   underrun_clr_i,
  output logic                   fifo_rd_en_o,
  output logic                   smp_load_o,
  output logic [DATAWIDTH-1:0]   smp_data_o,
  output logic [SAMPLE_RATE-1:0] phase_o,
  output logic                   phase_valid_o,
  output logic                   underrun_o,
  output logic [UCNT_W-1:0]      underrun_cnt_o
);

  // Returned fetch data is registered one phase before the segment ends
  localparam logic [SAMPLE_RATE-1:0] PHASE_CAPTURE = SAMPLE_RATE'((1 << SAMPLE_RATE) - 2);

  state_e state_q, state_d;

  logic [1:0]           rd_cnt_q, rd_cnt_d;
  logic [1:0]           ld_cnt_q, ld_cnt_d;
  logic                 rd_pend_q;
  logic                 smp_load_q;
  logic [DATAWIDTH-1:0] smp_data_q;
  logic                 underrun_q, underrun_d;
  logic [UCNT_W-1:0]    ucnt_q, ucnt_d;

  logic [SAMPLE_RATE-1:0] phase;
  logic                   phase_at_fetch;
  logic                   phase_at_last;
  logic                   rd_en;
  logic                   prime_capture;
  logic                   run_capture;
  logic                   new_underrun;

  interp_phase_cnt #(
    .SAMPLE_RATE(SAMPLE_RATE)
  ) u_phase_cnt (
    .clk             (clk),
    .rst             (rst),
    .clr_i           (state_q != ST_RUN),
    .inc_i           (state_q == ST_RUN),
    .phase_o         (phase),
    .phase_at_fetch_o(phase_at_fetch),
    .phase_at_last_o (phase_at_last)
  );

  // Priming data is only kept while enable holds; a drop discards in-flight reads
  assign prime_capture = (state_q == ST_PRIME) && enable_i && rd_pend_q;
  // In RUN a load fires every segment, even when the fetch underran
  assign run_capture   = (state_q == ST_RUN) && (phase == PHASE_CAPTURE);
  assign new_underrun  = (state_q == ST_RUN) && phase_at_fetch && fifo_empty_i;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: stop in RUN waits for the segment boundary, PRIME aborts at once
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && fifo_half_i) state_d = ST_PRIME;
      end
      ST_PRIME: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (ld_cnt_q == 2'd2) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (phase_at_last && !enable_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs from state: read strobe is always gated by FIFO empty
  always_comb begin
    rd_en         = 1'b0;
    phase_valid_o = 1'b0;
    case (state_q)
      ST_PRIME: begin
        rd_en = enable_i && (rd_cnt_q != 2'd2) && !fifo_empty_i;
      end
      ST_RUN: begin
        rd_en         = phase_at_fetch && !fifo_empty_i;
        phase_valid_o = 1'b1;
      end
      default: begin
        rd_en         = 1'b0;
        phase_valid_o = 1'b0;
      end
    endcase
  end

  // Priming read/load counters, held at zero outside PRIME
  always_comb begin
    rd_cnt_d = '0;
    ld_cnt_d = '0;
    if (state_q == ST_PRIME) begin
      rd_cnt_d = rd_cnt_q + {1'b0, rd_en};
      ld_cnt_d = ld_cnt_q + {1'b0, prime_capture};
    end
  end

  // Sample pipeline: read pending flag, registered sample and load strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q   <= '0;
      ld_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      smp_load_q <= 1'b0;
      smp_data_q <= '0;
    end else begin
      rd_cnt_q   <= rd_cnt_d;
      ld_cnt_q   <= ld_cnt_d;
      rd_pend_q  <= rd_en;
      smp_load_q <= prime_capture || run_capture;
      if ((prime_capture || run_capture) && rd_pend_q) begin
        smp_data_q <= fifo_dout_i;
      end
    end
  end

  // Underrun stats: clear first so a coincident underrun still counts as one
  always_comb begin
    underrun_d = underrun_q;
    ucnt_d     = ucnt_q;
    if (underrun_clr_i) begin
      underrun_d = 1'b0;
      ucnt_d     = '0;
    end
    if (new_underrun) begin
      underrun_d = 1'b1;
      if (ucnt_d != '1) ucnt_d = ucnt_d + 1'b1;
    end
  end

  // Underrun registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underrun_q <= 1'b0;
      ucnt_q     <= '0;
    end else begin
      underrun_q <= underrun_d;
      ucnt_q     <= ucnt_d;
    end
  end

  assign fifo_rd_en_o   = rd_en;
  assign smp_load_o     = smp_load_q;
  assign smp_data_o     = smp_data_q;
  assign phase_o        = phase;
  assign underrun_o     = underrun_q;
  assign underrun_cnt_o = ucnt_q;

endmodule

// File: tb/tb_interp_feed_ctrl.sv
// Testbench for interp_feed_ctrl: a queue-backed FIFO drives the DUT and a
// transaction-level model (scheduled loads, time-based phase) predicts outputs.
module tb_interp_feed_ctrl;

   localparam int SR = 4;
   localparam int N = 16;
   localparam int DW = 14;
   localparam int UW = 8;
   localparam int HALF_LVL = 3;
   localparam int FIFO_DEPTH = 6;

   localparam int S_RAND = 0;
   localparam int S_STARVE = 1;
   localparam int S_STARVE_CLR = 2;
   localparam int S_FEED = 3;
   localparam int S_STOP = 4;
   localparam int S_PRIMEDROP = 5;

   typedef enum {MM_IDLE, MM_PRIME, MM_RUN} mmode_e;
   typedef struct {
      int due;
      logic [DW-1:0] val;
   } load_t;

   logic clk = 1'b0;
   logic rst;
   logic enable;
   logic fifoHalf;
   logic fifoEmpty;
   logic [DW-1:0] fifoDout;
   logic underrunClr;
   logic fifoRdEn;
   logic smpLoad;
   logic [DW-1:0] smpData;
   logic [SR-1:0] phase;
   logic phaseValid;
   logic underrun;
   logic [UW-1:0] underrunCnt;

   logic [DW-1:0] fifoQ[$];
   logic [DW-1:0] obsLoads[$];

   mmode_e mMode;
   int mReads;
   int mLoadsDone;
   load_t mLoads[$];
   int mT0;
   logic mPendValid;
   logic [DW-1:0] mPendWord;
   logic [DW-1:0] mSmp;
   logic mUnder;
   int mCnt;

   int checks;
   int failures;
   int cyc;
   int startCyc;
   int firstValidCyc;
   int guard;
   int loadsBefore;
   logic stopLatched;
   logic dropLatched;

   interp_feed_ctrl #(
      .SAMPLE_RATE(SR),
      .DATAWIDTH(DW),
      .UCNT_W(UW)
   ) dut (
      .clk(clk),
      .rst(rst),
      .enable_i(enable),
      .fifo_half_i(fifoHalf),
      .fifo_empty_i(fifoEmpty),
      .fifo_dout_i(fifoDout),
      .underrun_clr_i(underrunClr),
      .fifo_rd_en_o(fifoRdEn),
      .smp_load_o(smpLoad),
      .smp_data_o(smpData),
      .phase_o(phase),
      .phase_valid_o(phaseValid),
      .underrun_o(underrun),
      .underrun_cnt_o(underrunCnt)
   );

   // Free-running clock, 10 time units per period
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Model view of the segment position, derived from elapsed run time
   function automatic int curPhase();
      return (mMode == MM_RUN) ? ((cyc - mT0) % N) : 0;
   endfunction

   task automatic resetModel();
      mMode = MM_IDLE;
      mReads = 0;
      mLoadsDone = 0;
      mLoads.delete();
      mT0 = 0;
      mPendValid = 1'b0;
      mPendWord = '0;
      mSmp = '0;
      mUnder = 1'b0;
      mCnt = 0;
   endtask

   task automatic feedFifo();
      if (fifoQ.size() < FIFO_DEPTH - 1) fifoQ.push_back(DW'($urandom));
   endtask

   // Drives enable, FIFO contents and clear pulses according to the scenario
   task automatic applyStimulus(input int mode);
      int ph;
      ph = curPhase();
      underrunClr = 1'b0;
      case (mode)
         S_RAND: begin
            if (enable) begin
               if ($urandom_range(0, 39) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               enable = 1'b1;
            end
            if ($urandom_range(0, 10) == 0 && fifoQ.size() < FIFO_DEPTH) fifoQ.push_back(DW'($urandom));
            underrunClr = ($urandom_range(0, 49) == 0);
         end
         S_STARVE: enable = 1'b1;
         S_STARVE_CLR: begin
            enable = 1'b1;
            underrunClr = (mMode == MM_RUN) && (ph == N - 3);
         end
         S_FEED: begin
            enable = 1'b1;
            feedFifo();
         end
         S_STOP: begin
            feedFifo();
            if (mMode == MM_RUN && ph == N - 2) stopLatched = 1'b1;
            enable = !stopLatched;
         end
         S_PRIMEDROP: begin
            feedFifo();
            if (mMode == MM_PRIME && mReads >= 1) dropLatched = 1'b1;
            enable = !dropLatched;
         end
         default: enable = 1'b0;
      endcase
      fifoEmpty = (fifoQ.size() == 0);
      fifoHalf = (fifoQ.size() >= HALF_LVL);
   endtask

   // One clock: stimulus on the falling edge, compare, advance model, then FIFO pop
   task automatic stepCycle(input int mode);
      logic expRd;
      logic expLoad;
      logic rdSeen;
      logic newUnder;
      int ph;
      load_t ld;
      @(negedge clk);
      applyStimulus(mode);
      #1;
      ph = curPhase();
      expRd = 1'b0;
      expLoad = 1'b0;
      if (mMode == MM_PRIME) begin
         expRd = (mReads < 2) && enable && !fifoEmpty;
         if (mLoads.size() > 0 && mLoads[0].due == cyc) begin
            expLoad = 1'b1;
            mSmp = mLoads[0].val;
            mLoads.delete(0);
            mLoadsDone++;
         end
      end else if (mMode == MM_RUN) begin
         expRd = (ph == N - 3) && !fifoEmpty;
         if (ph == N - 1) begin
            expLoad = 1'b1;
            if (mPendValid) mSmp = mPendWord;
            mPendValid = 1'b0;
         end
      end

      checkOutput("fifo_rd_en", 32'(fifoRdEn), 32'(expRd));
      checkOutput("smp_load", 32'(smpLoad), 32'(expLoad));
      checkOutput("smp_data", 32'(smpData), 32'(mSmp));
      checkOutput("phase", 32'(phase), 32'(ph));
      checkOutput("phase_valid", 32'(phaseValid), 32'(mMode == MM_RUN));
      checkOutput("underrun", 32'(underrun), 32'(mUnder));
      checkOutput("underrun_cnt", 32'(underrunCnt), 32'(mCnt));

      if (smpLoad === 1'b1) obsLoads.push_back(smpData);
      if (phaseValid === 1'b1 && firstValidCyc < 0) firstValidCyc = cyc;
      rdSeen = fifoRdEn;

      newUnder = (mMode == MM_RUN) && (ph == N - 3) && fifoEmpty;
      if (underrunClr) begin
         mUnder = 1'b0;
         mCnt = 0;
      end
      if (newUnder) begin
         mUnder = 1'b1;
         if (mCnt < 255) mCnt++;
      end

      case (mMode)
         MM_IDLE: begin
            if (enable && fifoHalf) begin
               mMode = MM_PRIME;
               mReads = 0;
               mLoadsDone = 0;
               mLoads.delete();
            end
         end
         MM_PRIME: begin
            if (expRd) begin
               ld.due = cyc + 2;
               ld.val = fifoQ[0];
               mLoads.push_back(ld);
               mReads++;
            end
            if (!enable) begin
               mMode = MM_IDLE;
               mLoads.delete();
            end else if (mLoadsDone == 2) begin
               mMode = MM_RUN;
               mT0 = cyc + 1;
               mPendValid = 1'b0;
            end
         end
         default: begin
            if (expRd) begin
               mPendValid = 1'b1;
               mPendWord = fifoQ[0];
            end
            if (ph == N - 1 && !enable) mMode = MM_IDLE;
         end
      endcase

      @(posedge clk);
      #1;
      if (rdSeen === 1'b1 && fifoQ.size() > 0) fifoDout = fifoQ.pop_front();
      cyc++;
   endtask

   // Global time bound so the bench can never hang
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Scenario sequence
   initial begin
      checks = 0;
      failures = 0;
      cyc = 0;
      firstValidCyc = -1;
      stopLatched = 1'b0;
      dropLatched = 1'b0;
      rst = 1'b1;
      enable = 1'b0;
      fifoHalf = 1'b0;
      fifoEmpty = 1'b1;
      underrunClr = 1'b0;
      fifoDout = '0;
      resetModel();

      #2;
      checkOutput("reset_rd_en", 32'(fifoRdEn), 0);
      checkOutput("reset_load", 32'(smpLoad), 0);
      checkOutput("reset_data", 32'(smpData), 0);
      checkOutput("reset_phase", 32'(phase), 0);
      checkOutput("reset_valid", 32'(phaseValid), 0);
      checkOutput("reset_underrun", 32'(underrun), 0);
      checkOutput("reset_ucnt", 32'(underrunCnt), 0);
      @(negedge clk);
      rst = 1'b0;

      $display("[TB] priming with preloaded samples");
      fifoQ.push_back(14'h0010);
      fifoQ.push_back(14'h0020);
      fifoQ.push_back(14'h0030);
      startCyc = cyc;
      repeat (40) stepCycle(S_FEED);
      checkOutput("first_valid_latency", 32'(firstValidCyc - startCyc), 32'd5);
      if (obsLoads.size() >= 3) begin
         checkOutput("prime_load0", 32'(obsLoads[0]), 32'h0010);
         checkOutput("prime_load1", 32'(obsLoads[1]), 32'h0020);
         checkOutput("run_load0", 32'(obsLoads[2]), 32'h0030);
      end else begin
         checkOutput("early_load_count", 32'(obsLoads.size()), 32'd3);
      end

      $display("[TB] starving FIFO for saturation");
      repeat (16 * 262) stepCycle(S_STARVE);
      checkOutput("ucnt_saturated", 32'(underrunCnt), 32'hFF);
      checkOutput("underrun_sticky", 32'(underrun), 32'd1);

      $display("[TB] clear coincident with underrun");
      repeat (40) stepCycle(S_STARVE_CLR);
      checkOutput("clr_with_underrun_cnt", 32'(underrunCnt), 32'd1);
      checkOutput("clr_with_underrun_flag", 32'(underrun), 32'd1);

      $display("[TB] stop at phase 14");
      stopLatched = 1'b0;
      repeat (48) stepCycle(S_STOP);
      checkOutput("stop_idle_valid", 32'(phaseValid), 32'd0);

      $display("[TB] enable dropped during priming");
      dropLatched = 1'b0;
      loadsBefore = obsLoads.size();
      repeat (20) stepCycle(S_PRIMEDROP);
      checkOutput("primedrop_no_load", 32'(obsLoads.size() - loadsBefore), 32'd0);
      checkOutput("primedrop_idle", 32'(phaseValid), 32'd0);

      $display("[TB] randomized traffic");
      repeat (3000) stepCycle(S_RAND);

      $display("[TB] asynchronous reset mid-run");
      guard = 0;
      while (!(mMode == MM_RUN && curPhase() == 7) && guard < 300) begin
         stepCycle(S_FEED);
         guard++;
      end
      checkOutput("reach_phase7", 32'(guard < 300), 32'd1);
      checkOutput("pre_reset_phase", 32'(phase), 32'd7);
      rst = 1'b1;
      enable = 1'b0;
      #1;
      checkOutput("async_rd_en", 32'(fifoRdEn), 0);
      checkOutput("async_load", 32'(smpLoad), 0);
      checkOutput("async_data", 32'(smpData), 0);
      checkOutput("async_phase", 32'(phase), 0);
      checkOutput("async_valid", 32'(phaseValid), 0);
      checkOutput("async_underrun", 32'(underrun), 0);
      checkOutput("async_ucnt", 32'(underrunCnt), 0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      resetModel();
      repeat (40) stepCycle(S_FEED);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
